psum_line_accumulator: RTL and testbench

- Consumer end of the line conv engine's per-kernel psum outputs (o_psum_knN / o_psum_knN_val).
- Accumulates NUM_KERNEL independent psum streams over LINE_LEN output positions and cfg_num_pass input-channel passes into an internal line store.
- After the final pass, drains one position per beat, all kernels packed, over a valid/ready stream toward the output writer.

---
 rtl/psum_line_accumulator_pkg.sv | 29 ++
 rtl/psum_line_accumulator_if.sv | 33 +++
 rtl/psum_line_accumulator_lane_acc.sv | 57 +++++
 rtl/psum_line_accumulator.sv | 151 +++++++++++++++
 tb/tb_psum_line_accumulator.sv | 397 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/psum_line_accumulator_pkg.sv
// Shared types and arithmetic for the psum line accumulator.
// Holds the FSM encoding, the default line geometry and the saturating adder.
package psum_line_accumulator_pkg;

   localparam int DEF_ACC_WIDTH = 16;
   localparam int DEF_LINE_LEN  = 16;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACCUM = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   // Signed add clamped to the range of a width-bit two's complement value.
   function automatic longint sat_add(input longint a, input longint b, input int width);
      longint sum;
      longint hi;
      longint lo;
      sum = a + b;
      hi  = (longint'(1) <<< (width - 1)) - 1;
      lo  = -hi - 1;
      if (sum > hi)
         sum = hi;
      else if (sum < lo)
         sum = lo;
      return sum;
   endfunction

endpackage

// File: rtl/psum_line_accumulator_if.sv
// Psum lanes from the conv engine plus the packed valid/ready output stream.
// The accumulator takes the slave side; the producer/consumer pair takes master.
interface psum_line_accumulator_if #(
   parameter int BIT_WIDTH  = 8,
   parameter int ACC_WIDTH  = 16,
   parameter int NUM_KERNEL = 4
);
   logic signed [BIT_WIDTH-1:0]        i_psum_kn0;
   logic signed [BIT_WIDTH-1:0]        i_psum_kn1;
   logic signed [BIT_WIDTH-1:0]        i_psum_kn2;
   logic signed [BIT_WIDTH-1:0]        i_psum_kn3;
   logic                               i_psum_kn0_val;
   logic                               i_psum_kn1_val;
   logic                               i_psum_kn2_val;
   logic                               i_psum_kn3_val;
   logic [ACC_WIDTH*NUM_KERNEL-1:0]    o_data;
   logic                               o_data_val;
   logic                               i_data_rdy;

   modport slave (
      input  i_psum_kn0, i_psum_kn1, i_psum_kn2, i_psum_kn3,
      input  i_psum_kn0_val, i_psum_kn1_val, i_psum_kn2_val, i_psum_kn3_val,
      input  i_data_rdy,
      output o_data, o_data_val
   );

   modport master (
      output i_psum_kn0, i_psum_kn1, i_psum_kn2, i_psum_kn3,
      output i_psum_kn0_val, i_psum_kn1_val, i_psum_kn2_val, i_psum_kn3_val,
      output i_data_rdy,
      input  o_data, o_data_val
   );
endinterface

// File: rtl/psum_line_accumulator_lane_acc.sv
// One kernel lane: LINE_LEN-deep accumulator store with its own write pointer.
// Pass 0 overwrites, later passes add with saturation; reads use the shared drain address.
module psum_lane_acc
   import psum_line_accumulator_pkg::*;
#(
   parameter int  BIT_WIDTH = 8,
   parameter int  ACC_WIDTH = DEF_ACC_WIDTH,
   parameter int  LINE_LEN  = DEF_LINE_LEN,
   localparam int AW        = $clog2(LINE_LEN),
   localparam int PW        = $clog2(LINE_LEN + 1)
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic signed [BIT_WIDTH-1:0] psum,
   input  logic                        psum_val,
   input  logic                        accept_en,
   input  logic                        first_pass,
   input  logic                        clr_ptr,
   input  logic [AW-1:0]               rd_addr,
   output logic signed [ACC_WIDTH-1:0] rd_data,
   output logic                        lane_full,
   output logic                        drop
);

   logic [PW-1:0]               wr_ptr;
   logic signed [ACC_WIDTH-1:0] mem [LINE_LEN];
   logic signed [ACC_WIDTH-1:0] psum_ext;
   logic signed [ACC_WIDTH-1:0] wr_data;
   logic                        wr_en;

   assign lane_full = (wr_ptr == PW'(LINE_LEN));
   assign wr_en     = accept_en && psum_val && !lane_full;
   // Any beat that is not written is a drop: wrong state or lane already full.
   assign drop      = psum_val && !wr_en;
   assign psum_ext  = ACC_WIDTH'(psum);

   assign wr_data = first_pass ? psum_ext
                  : ACC_WIDTH'(sat_add(longint'(mem[wr_ptr[AW-1:0]]), longint'(psum_ext), ACC_WIDTH));

   always_ff @(posedge clk) begin
      if (rst)
         wr_ptr <= '0;
      else if (clr_ptr)
         wr_ptr <= '0;
      else if (wr_en)
         wr_ptr <= wr_ptr + PW'(1);
   end

   // NOTE: the store has no reset; pass 0 overwrites every entry before it is read.
   always_ff @(posedge clk) begin
      if (wr_en)
         mem[wr_ptr[AW-1:0]] <= wr_data;
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/psum_line_accumulator.sv
// Collects four kernel psum streams over several passes, then drains one
// position per beat (all kernels packed) on a valid/ready stream.
module psum_line_accumulator
   import psum_line_accumulator_pkg::*;
#(
   parameter int BIT_WIDTH  = 8,
   parameter int NUM_KERNEL = 4,
   parameter int ACC_WIDTH  = DEF_ACC_WIDTH,
   parameter int LINE_LEN   = DEF_LINE_LEN,
   parameter int PASS_WIDTH = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_start,
   input  logic [PASS_WIDTH-1:0] cfg_num_pass,
   psum_line_accumulator_if.slave bus,
   output logic                  o_busy,
   output logic                  o_done,
   output logic                  o_err_drop,
   output logic [PASS_WIDTH-1:0] o_pass_cnt
);

   localparam int AW = $clog2(LINE_LEN);

   state_t                          state;
   logic [PASS_WIDTH-1:0]           pass_cnt;
   logic [PASS_WIDTH-1:0]           num_pass;
   logic [AW-1:0]                   rd_ptr;
   logic [AW-1:0]                   rd_addr;
   logic [ACC_WIDTH*NUM_KERNEL-1:0] data_q;
   logic [ACC_WIDTH*NUM_KERNEL-1:0] rd_pack;
   logic                            data_val;
   logic                            err_drop;

   logic signed [BIT_WIDTH-1:0]     psum      [NUM_KERNEL];
   logic signed [ACC_WIDTH-1:0]     rd_data   [NUM_KERNEL];
   logic [NUM_KERNEL-1:0]           psum_val;
   logic [NUM_KERNEL-1:0]           lane_full;
   logic [NUM_KERNEL-1:0]           lane_drop;

   logic hs;
   logic at_last;
   logic last_pass;
   logic start_line;
   logic turnover;

   // The engine exposes exactly four named lanes.
   assign psum[0]     = bus.i_psum_kn0;
   assign psum[1]     = bus.i_psum_kn1;
   assign psum[2]     = bus.i_psum_kn2;
   assign psum[3]     = bus.i_psum_kn3;
   assign psum_val[0] = bus.i_psum_kn0_val;
   assign psum_val[1] = bus.i_psum_kn1_val;
   assign psum_val[2] = bus.i_psum_kn2_val;
   assign psum_val[3] = bus.i_psum_kn3_val;

   assign hs         = (state == ST_DRAIN) && data_val && bus.i_data_rdy;
   assign at_last    = (rd_ptr == AW'(LINE_LEN - 1));
   assign last_pass  = (pass_cnt == num_pass - PASS_WIDTH'(1));
   assign start_line = (state == ST_IDLE) && i_start;
   assign turnover   = (state == ST_ACCUM) && (&lane_full) && !last_pass;

   // Look one entry ahead on a handshake so the next beat loads in the same cycle.
   assign rd_addr = (hs && !at_last) ? rd_ptr + AW'(1) : rd_ptr;

   for (genvar k = 0; k < NUM_KERNEL; k++) begin : g_lane
      psum_lane_acc #(
         .BIT_WIDTH (BIT_WIDTH),
         .ACC_WIDTH (ACC_WIDTH),
         .LINE_LEN  (LINE_LEN)
      ) u_lane (
         .clk        (clk),
         .rst        (rst),
         .psum       (psum[k]),
         .psum_val   (psum_val[k]),
         .accept_en  (state == ST_ACCUM),
         .first_pass (pass_cnt == '0),
         .clr_ptr    (start_line || turnover),
         .rd_addr    (rd_addr),
         .rd_data    (rd_data[k]),
         .lane_full  (lane_full[k]),
         .drop       (lane_drop[k])
      );
   end

   // NOTE: give every always_comb output a default first so no latch is inferred.
   always_comb begin
      rd_pack = '0;
      for (int k = 0; k < NUM_KERNEL; k++)
         rd_pack[k*ACC_WIDTH +: ACC_WIDTH] = rd_data[k];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_IDLE;
         pass_cnt <= '0;
         num_pass <= '0;
         rd_ptr   <= '0;
         data_q   <= '0;
         data_val <= 1'b0;
         err_drop <= 1'b0;
      end else begin
         if (|lane_drop)
            err_drop <= 1'b1;
         case (state)
            ST_IDLE: begin
               if (i_start) begin
                  state    <= ST_ACCUM;
                  num_pass <= (cfg_num_pass == '0) ? PASS_WIDTH'(1) : cfg_num_pass;
                  pass_cnt <= '0;
                  rd_ptr   <= '0;
                  err_drop <= 1'b0;
               end
            end
            ST_ACCUM: begin
               if (&lane_full) begin
                  if (last_pass) begin
                     state  <= ST_DRAIN;
                     rd_ptr <= '0;
                  end else begin
                     pass_cnt <= pass_cnt + PASS_WIDTH'(1);
                  end
               end
            end
            ST_DRAIN: begin
               if (!data_val) begin
                  data_q   <= rd_pack;
                  data_val <= 1'b1;
               end else if (bus.i_data_rdy) begin
                  if (at_last) begin
                     state    <= ST_IDLE;
                     data_val <= 1'b0;
                  end else begin
                     rd_ptr <= rd_ptr + AW'(1);
                     data_q <= rd_pack;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign bus.o_data     = data_q;
   assign bus.o_data_val = data_val;
   assign o_busy         = (state != ST_IDLE);
   assign o_done         = hs && at_last;
   assign o_err_drop     = err_drop;
   assign o_pass_cnt     = pass_cnt;

endmodule

// File: tb/tb_psum_line_accumulator.sv
// Scoreboard bench: a 16-bit instance for the main scenarios and an 8-bit
// instance for saturation, sharing the psum lane drivers.
module tb_psum_line_accumulator;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic              start_a = 1'b0, start_b = 1'b0;
   logic [3:0]        cfg = '0;
   logic              rdy_a = 1'b0, rdy_b = 1'b0;
   logic signed [7:0] ps [4];
   logic              pv [4];
   logic              sel = 1'b0;

   psum_line_accumulator_if #(.BIT_WIDTH(8), .ACC_WIDTH(16), .NUM_KERNEL(4)) bus_a ();
   psum_line_accumulator_if #(.BIT_WIDTH(8), .ACC_WIDTH(8),  .NUM_KERNEL(4)) bus_b ();

   assign bus_a.i_psum_kn0 = ps[0];  assign bus_a.i_psum_kn0_val = pv[0];
   assign bus_a.i_psum_kn1 = ps[1];  assign bus_a.i_psum_kn1_val = pv[1];
   assign bus_a.i_psum_kn2 = ps[2];  assign bus_a.i_psum_kn2_val = pv[2];
   assign bus_a.i_psum_kn3 = ps[3];  assign bus_a.i_psum_kn3_val = pv[3];
   assign bus_b.i_psum_kn0 = ps[0];  assign bus_b.i_psum_kn0_val = pv[0];
   assign bus_b.i_psum_kn1 = ps[1];  assign bus_b.i_psum_kn1_val = pv[1];
   assign bus_b.i_psum_kn2 = ps[2];  assign bus_b.i_psum_kn2_val = pv[2];
   assign bus_b.i_psum_kn3 = ps[3];  assign bus_b.i_psum_kn3_val = pv[3];
   assign bus_a.i_data_rdy = rdy_a;
   assign bus_b.i_data_rdy = rdy_b;

   logic       busy_a, done_a, err_a, busy_b, done_b, err_b;
   logic [3:0] pass_a, pass_b;

   psum_line_accumulator #(.BIT_WIDTH(8), .NUM_KERNEL(4), .ACC_WIDTH(16), .LINE_LEN(16), .PASS_WIDTH(4)) dut (
      .clk(clk), .rst(rst), .i_start(start_a), .cfg_num_pass(cfg), .bus(bus_a),
      .o_busy(busy_a), .o_done(done_a), .o_err_drop(err_a), .o_pass_cnt(pass_a));

   psum_line_accumulator #(.BIT_WIDTH(8), .NUM_KERNEL(4), .ACC_WIDTH(8), .LINE_LEN(16), .PASS_WIDTH(4)) dut8 (
      .clk(clk), .rst(rst), .i_start(start_b), .cfg_num_pass(cfg), .bus(bus_b),
      .o_busy(busy_b), .o_done(done_b), .o_err_drop(err_b), .o_pass_cnt(pass_b));

   logic        cur_val, cur_done, cur_busy, cur_err;
   logic [3:0]  cur_pass;
   logic [63:0] cur_data;
   assign cur_val  = sel ? bus_b.o_data_val : bus_a.o_data_val;
   assign cur_data = sel ? {32'b0, bus_b.o_data} : bus_a.o_data;
   assign cur_done = sel ? done_b : done_a;
   assign cur_busy = sel ? busy_b : busy_a;
   assign cur_err  = sel ? err_b  : err_a;
   assign cur_pass = sel ? pass_b : pass_a;

   int errors = 0;
   int checks = 0;
   logic [63:0] exp_q [$];

   function automatic logic [63:0] pack16(input int a, input int b, input int c, input int d);
      return {d[15:0], c[15:0], b[15:0], a[15:0]};
   endfunction

   function automatic logic [63:0] pack8(input int a, input int b, input int c, input int d);
      return {32'b0, d[7:0], c[7:0], b[7:0], a[7:0]};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_rdy(input logic r);
      if (sel) rdy_b = r; else rdy_a = r;
   endtask

   task automatic pulse_start(input logic [3:0] n);
      cfg = n;
      if (sel) start_b = 1'b1; else start_a = 1'b1;
      tick();
      start_a = 1'b0;
      start_b = 1'b0;
   endtask

   task automatic push_line(input logic [63:0] beat, input bit pos16);
      for (int p = 0; p < 16; p++)
         exp_q.push_back(pos16 ? pack16(p, p, p, p) : beat);
   endtask

   task automatic idle_lanes();
      for (int k = 0; k < 4; k++) pv[k] = 1'b0;
   endtask

   // Drives all passes; lane k waits dly[k] cycles each pass, lane3 optionally half duty.
   task automatic feed(input int npass, input int d1, input int d2, input bit half3, input bit pos_mode,
                       input int c0, input int c1, input int c2, input int c3, input bit extra0);
      int dly [4];
      int cv [4];
      int sent [4];
      int cyc;
      int exp_pass;
      bit bad_pass;
      bit extra_done;
      dly = '{0, d1, d2, 0};
      cv  = '{c0, c1, c2, c3};
      extra_done = 1'b0;
      for (int p = 0; p < npass; p++) begin
         sent = '{0, 0, 0, 0};
         cyc = 0;
         bad_pass = 1'b0;
         while (sent[0] < 16 || sent[1] < 16 || sent[2] < 16 || sent[3] < 16) begin
            for (int k = 0; k < 4; k++) begin
               pv[k] = 1'b0;
               if (sent[k] < 16 && cyc >= dly[k] && !(half3 && k == 3 && cyc % 2 == 1)) begin
                  pv[k] = 1'b1;
                  ps[k] = pos_mode ? 8'(sent[k]) : 8'(cv[k]);
                  sent[k]++;
               end
            end
            if (extra0 && p == 0 && !extra_done && !pv[0] && sent[0] == 16 &&
                (sent[1] < 16 || sent[2] < 16 || sent[3] < 16)) begin
               pv[0] = 1'b1;
               ps[0] = 8'sd99;
               extra_done = 1'b1;
            end
            if (cur_pass !== 4'(p)) bad_pass = 1'b1;
            tick();
            cyc++;
         end
         idle_lanes();
         checks++;
         if (bad_pass) begin
            errors++;
            $display("FAIL pass_cnt_during_fill: pass %0d counter moved before every lane completed", p);
         end
         checks++;
         if (cur_pass !== 4'(p)) begin
            errors++;
            $display("FAIL turnover_cycle: pass_cnt=%0d want %0d", cur_pass, p);
         end
         tick();
         exp_pass = (p < npass - 1) ? p + 1 : p;
         checks++;
         if (cur_pass !== 4'(exp_pass) || cur_busy !== 1'b1) begin
            errors++;
            $display("FAIL after_turnover: pass_cnt=%0d busy=%b want %0d busy=1", cur_pass, cur_busy, exp_pass);
         end
      end
   endtask

   task automatic drain(input bit rand_rdy, input int rst_at, input bit inject);
      int hs;
      int first_it;
      bit prev_stall;
      bit r;
      bit exp_done;
      logic [63:0] prev_data;
      logic [63:0] exp;
      hs = 0;
      first_it = -1;
      prev_stall = 1'b0;
      prev_data = '0;
      checks++;
      if (cur_val !== 1'b0) begin
         errors++;
         $display("FAIL drain_entry_val: val=%b want 0", cur_val);
      end
      for (int it = 0; it < 200 && hs < 16; it++) begin
         r = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
         set_rdy(r);
         if (inject)
            for (int k = 0; k < 4; k++) begin pv[k] = 1'b1; ps[k] = 8'sd55; end
         if (rand_rdy && it == 3) begin
            if (sel) start_b = 1'b1; else start_a = 1'b1;
         end else begin
            start_a = 1'b0;
            start_b = 1'b0;
         end
         if (rst_at >= 0 && hs == rst_at && cur_val) begin
            rst = 1'b1;
            tick();
            rst = 1'b0;
            checks++;
            if (cur_val !== 1'b0 || cur_done !== 1'b0 || cur_busy !== 1'b0 || cur_pass !== 4'd0) begin
               errors++;
               $display("FAIL reset_mid_drain: val=%b done=%b busy=%b pass=%0d want 0 0 0 0",
                        cur_val, cur_done, cur_busy, cur_pass);
            end
            tick();
            checks++;
            if (cur_val !== 1'b0 || cur_done !== 1'b0) begin
               errors++;
               $display("FAIL after_reset_quiet: val=%b done=%b want 0 0", cur_val, cur_done);
            end
            exp_q.delete();
            idle_lanes();
            set_rdy(1'b0);
            return;
         end
         #1;
         if (cur_val && first_it < 0) first_it = it;
         exp_done = cur_val && r && (hs == 15);
         checks++;
         if (cur_done !== exp_done) begin
            errors++;
            $display("FAIL done_pulse: done=%b want %b at handshake %0d", cur_done, exp_done, hs);
         end
         if (cur_val) begin
            if (prev_stall) begin
               checks++;
               if (cur_data !== prev_data) begin
                  errors++;
                  $display("FAIL stall_hold: data=%h want %h", cur_data, prev_data);
               end
            end
            if (r) begin
               checks++;
               if (exp_q.size() == 0) begin
                  errors++;
                  $display("FAIL extra_beat: data=%h with empty scoreboard", cur_data);
               end else begin
                  exp = exp_q.pop_front();
                  if (cur_data !== exp) begin
                     errors++;
                     $display("FAIL beat_%0d: data=%h want %h", hs, cur_data, exp);
                  end
               end
               hs++;
            end
         end
         prev_stall = cur_val && !r;
         prev_data = cur_data;
         @(posedge clk);
         #1;
      end
      idle_lanes();
      start_a = 1'b0;
      start_b = 1'b0;
      set_rdy(1'b0);
      checks++;
      if (hs != 16) begin
         errors++;
         $display("FAIL handshake_count: got %0d want 16 within budget", hs);
      end
      checks++;
      if (first_it != 1) begin
         errors++;
         $display("FAIL first_beat_latency: first valid at cycle %0d want 1", first_it);
      end
      checks++;
      if (cur_val !== 1'b0 || cur_busy !== 1'b0 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain_end: val=%b busy=%b left=%0d want 0 0 0", cur_val, cur_busy, exp_q.size());
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      checks++;
      if (bus_a.o_data_val !== 1'b0 || bus_a.o_data !== 64'd0 || busy_a !== 1'b0 ||
          done_a !== 1'b0 || err_a !== 1'b0 || pass_a !== 4'd0) begin
         errors++;
         $display("FAIL reset_outputs: val=%b data=%h busy=%b done=%b err=%b pass=%0d want all 0",
                  bus_a.o_data_val, bus_a.o_data, busy_a, done_a, err_a, pass_a);
      end
      checks++;
      if (bus_b.o_data_val !== 1'b0 || busy_b !== 1'b0 || err_b !== 1'b0) begin
         errors++;
         $display("FAIL reset_outputs_8b: val=%b busy=%b err=%b want 0 0 0", bus_b.o_data_val, busy_b, err_b);
      end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_single_pass();
      sel = 1'b0;
      for (int c = 0; c < 2; c++) begin
         pulse_start(4'(c));
         checks++;
         if (cur_busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_after_start: busy=%b want 1 (cfg=%0d)", cur_busy, c);
         end
         push_line('0, 1'b1);
         feed(1, 0, 0, 1'b0, 1'b1, 0, 0, 0, 0, 1'b0);
         drain(1'b0, -1, 1'b0);
         checks++;
         if (cur_err !== 1'b0) begin
            errors++;
            $display("FAIL single_err_drop: err=%b want 0", cur_err);
         end
      end
   endtask

   task automatic test_multi_pass();
      sel = 1'b0;
      pulse_start(4'd3);
      push_line(pack16(15, -6, 0, 381), 1'b0);
      feed(3, 0, 0, 1'b0, 1'b0, 5, -2, 0, 127, 1'b0);
      drain(1'b0, -1, 1'b0);
   endtask

   task automatic test_lane_skew();
      sel = 1'b0;
      pulse_start(4'd2);
      push_line(pack16(2, 2, 2, 2), 1'b0);
      feed(2, 0, 7, 1'b1, 1'b0, 1, 1, 1, 1, 1'b0);
      drain(1'b0, -1, 1'b0);
      checks++;
      if (cur_err !== 1'b0) begin
         errors++;
         $display("FAIL skew_err_drop: err=%b want 0", cur_err);
      end
   endtask

   task automatic test_drops();
      sel = 1'b0;
      for (int k = 0; k < 4; k++) begin pv[k] = 1'b1; ps[k] = 8'sd7; end
      tick();
      idle_lanes();
      checks++;
      if (cur_err !== 1'b1) begin
         errors++;
         $display("FAIL drop_in_idle: err=%b want 1", cur_err);
      end
      pulse_start(4'd1);
      checks++;
      if (cur_err !== 1'b0) begin
         errors++;
         $display("FAIL start_clears_err: err=%b want 0", cur_err);
      end
      push_line(pack16(1, 1, 1, 1), 1'b0);
      feed(1, 0, 0, 1'b0, 1'b0, 1, 1, 1, 1, 1'b0);
      drain(1'b0, -1, 1'b1);
      checks++;
      if (cur_err !== 1'b1) begin
         errors++;
         $display("FAIL drop_in_drain: err=%b want 1", cur_err);
      end
      pulse_start(4'd1);
      push_line(pack16(1, 1, 1, 1), 1'b0);
      feed(1, 3, 0, 1'b0, 1'b0, 1, 1, 1, 1, 1'b1);
      checks++;
      if (cur_err !== 1'b1) begin
         errors++;
         $display("FAIL drop_lane_full: err=%b want 1", cur_err);
      end
      drain(1'b0, -1, 1'b0);
   endtask

   task automatic test_saturation();
      sel = 1'b1;
      pulse_start(4'd3);
      push_line(pack8(127, 127, 127, 127), 1'b0);
      feed(3, 0, 0, 1'b0, 1'b0, 100, 100, 100, 100, 1'b0);
      drain(1'b0, -1, 1'b0);
      pulse_start(4'd3);
      push_line(pack8(-128, -128, -128, -128), 1'b0);
      feed(3, 0, 0, 1'b0, 1'b0, -100, -100, -100, -100, 1'b0);
      drain(1'b0, -1, 1'b0);
      checks++;
      if (cur_err !== 1'b0) begin
         errors++;
         $display("FAIL sat_err_drop: err=%b want 0", cur_err);
      end
      sel = 1'b0;
   endtask

   task automatic test_backpressure_reset();
      sel = 1'b0;
      pulse_start(4'd1);
      push_line('0, 1'b1);
      feed(1, 0, 0, 1'b0, 1'b1, 0, 0, 0, 0, 1'b0);
      drain(1'b1, -1, 1'b0);
      pulse_start(4'd1);
      push_line('0, 1'b1);
      feed(1, 0, 0, 1'b0, 1'b1, 0, 0, 0, 0, 1'b0);
      drain(1'b0, 5, 1'b0);
   endtask

   initial begin
      for (int k = 0; k < 4; k++) begin ps[k] = '0; pv[k] = 1'b0; end
      test_reset();
      test_single_pass();
      test_multi_pass();
      test_lane_skew();
      test_drops();
      test_saturation();
      test_backpressure_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

endmodule
